// File: rtl/timing_manager_nch_pkg.sv
// timing_manager_pkg
// Shared definitions for the sensor-acquisition timing manager:
//   - tm_state_t : acquisition FSM states
//   - DEF_*      : default parameter values
//   - ch_lsb()   : LSB index of a channel's slice in the packed ch_time/ch_max buses
package timing_manager_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACQ  = 1'b1
    } tm_state_t;

    localparam int DEF_N_CH    = 10;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_RATIO_W = 16;

    // Channel ch occupies [ch*cnt_w +: cnt_w] of a packed per-channel bus
    function automatic int ch_lsb(input int ch, input int cnt_w);
        return ch * cnt_w;
    endfunction

endpackage

// File: rtl/timing_manager_nch_capture.sv
// tm_channel_capture
// One sensor channel's done-edge capture logic.
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   done          done level from the sensor IP
//   acq           window is open (FSM in ACQ)
//   en_active     channel is part of the current window
//   win_start     a new window starts at this edge (discards done_mask)
//   clr_max       clears ch_max (a simultaneous capture loads its own time)
//   count_time    time value to record on a capture
//   captured      combinational: a capture happens at this edge
//   done_mask     channel already captured in the current window
//   ch_time       last captured time
//   ch_max        largest captured time since reset / clr_max
module tm_channel_capture
    import timing_manager_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done,
    input  logic             acq,
    input  logic             en_active,
    input  logic             win_start,
    input  logic             clr_max,
    input  logic [CNT_W-1:0] count_time,
    output logic             captured,
    output logic             done_mask,
    output logic [CNT_W-1:0] ch_time,
    output logic [CNT_W-1:0] ch_max
);

    logic done_q;
    logic mask_live;

    // A window starting at this edge makes the old mask irrelevant, so an
    // edge landing on the trigger cycle counts towards the new window.
    assign mask_live = done_mask & ~win_start;
    assign captured  = acq & en_active & done & ~done_q & ~mask_live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            done_mask <= 1'b0;
            ch_time   <= '0;
            ch_max    <= '0;
        end else begin
            done_q    <= done;
            done_mask <= mask_live | captured;
            if (captured) begin
                ch_time <= count_time;
                if (clr_max || (count_time > ch_max)) begin
                    ch_max <= count_time;
                end
            end else if (clr_max) begin
                ch_max <= '0;
            end
        end
    end

endmodule

// File: rtl/timing_manager_nch.sv
// timing_manager_nch
// Divides PWM carrier events into acquisition triggers, times each enabled
// sensor's done edge inside the window, and reports completion/timeout/overrun.
// Ports:
//   clk, rst_n         clock / asynchronous active-low reset
//   event_qualifier    one-cycle pulse per carrier event
//   user_ratio         trigger every user_ratio+1 qualifier events
//   en_bits / en       channel enables / combinational copy
//   timeout            window limit in cycles, 0 = none
//   done               per-channel done levels
//   clr_isr, clr_max   clear sticky flags / clear maxima
//   trigger            one-cycle window start pulse
//   sched_isr          sticky: window finished (complete or timeout)
//   timeout_flag       sticky: last window ended by timeout
//   overrun_flag       sticky: trigger arrived while a window was open
//   late_mask          channels still missing at the timeout
//   busy               window open
//   count_time         cycles since last trigger, saturating
//   ch_time, ch_max    packed per-channel last/maximum captured times
module timing_manager_nch
    import timing_manager_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int RATIO_W = DEF_RATIO_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  event_qualifier,
    input  logic [RATIO_W-1:0]    user_ratio,
    input  logic [N_CH-1:0]       en_bits,
    input  logic [CNT_W-1:0]      timeout,
    input  logic [N_CH-1:0]       done,
    input  logic                  clr_isr,
    input  logic                  clr_max,
    output logic [N_CH-1:0]       en,
    output logic                  trigger,
    output logic                  sched_isr,
    output logic                  timeout_flag,
    output logic                  overrun_flag,
    output logic [N_CH-1:0]       late_mask,
    output logic                  busy,
    output logic [CNT_W-1:0]      count_time,
    output logic [N_CH*CNT_W-1:0] ch_time,
    output logic [N_CH*CNT_W-1:0] ch_max
);

    localparam logic [RATIO_W-1:0] RATIO_ONE = 1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    tm_state_t         state, state_nxt;
    logic [RATIO_W-1:0] ratio_cnt;
    logic [N_CH-1:0]   en_active;
    logic [N_CH-1:0]   done_mask;
    logic [N_CH-1:0]   captures;
    logic [N_CH-1:0]   cap_en;
    logic [CNT_W-1:0]  cap_time;
    logic              all_done;
    logic              timeout_hit;
    logic              latch_en;
    logic              set_isr;
    logic              set_timeout;
    logic              set_overrun;

    assign en   = en_bits;
    assign busy = (state == ACQ);

    // On the trigger edge the new window already applies: time restarts at 0
    // and the freshly sampled enables decide which edges count.
    assign cap_time    = trigger ? '0 : count_time;
    assign cap_en      = trigger ? en_bits : en_active;
    assign all_done    = (((done_mask | captures) & en_active) == en_active);
    assign timeout_hit = (timeout != '0) && (count_time == timeout);

    // Carrier-event divider; a count above a lowered ratio just wraps around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_cnt <= '0;
            trigger   <= 1'b0;
        end else begin
            trigger <= 1'b0;
            if (event_qualifier) begin
                if (ratio_cnt == user_ratio) begin
                    ratio_cnt <= '0;
                    trigger   <= 1'b1;
                end else begin
                    ratio_cnt <= ratio_cnt + RATIO_ONE;
                end
            end
        end
    end

    // Window timer, restarted by every trigger and held at its ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_time <= '0;
        end else if (trigger) begin
            count_time <= '0;
        end else if (count_time != CNT_MAX) begin
            count_time <= count_time + CNT_ONE;
        end
    end

    // A new trigger outranks finishing the old window; completion outranks timeout.
    always_comb begin
        state_nxt   = state;
        latch_en    = 1'b0;
        set_isr     = 1'b0;
        set_timeout = 1'b0;
        set_overrun = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    latch_en = 1'b1;
                    if (en_bits != '0) begin
                        state_nxt = ACQ;
                    end
                end
            end
            ACQ: begin
                if (trigger) begin
                    latch_en    = 1'b1;
                    set_overrun = 1'b1;
                end else if (all_done) begin
                    set_isr   = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    set_isr     = 1'b1;
                    set_timeout = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, enables and sticky flags; setting a flag beats clearing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            en_active    <= '0;
            sched_isr    <= 1'b0;
            timeout_flag <= 1'b0;
            overrun_flag <= 1'b0;
            late_mask    <= '0;
        end else begin
            state <= state_nxt;
            if (latch_en) begin
                en_active <= en_bits;
            end
            if (set_isr) begin
                sched_isr <= 1'b1;
            end else if (clr_isr) begin
                sched_isr <= 1'b0;
            end
            if (set_timeout) begin
                timeout_flag <= 1'b1;
            end else if (clr_isr) begin
                timeout_flag <= 1'b0;
            end
            if (set_overrun) begin
                overrun_flag <= 1'b1;
            end else if (clr_isr) begin
                overrun_flag <= 1'b0;
            end
            if (set_timeout) begin
                late_mask <= en_active & ~done_mask;
            end else if (trigger) begin
                late_mask <= '0;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam int LSB = ch_lsb(i, CNT_W);
        tm_channel_capture #(
            .CNT_W (CNT_W)
        ) u_cap (
            .clk        (clk),
            .rst_n      (rst_n),
            .done       (done[i]),
            .acq        (busy),
            .en_active  (cap_en[i]),
            .win_start  (trigger),
            .clr_max    (clr_max),
            .count_time (cap_time),
            .captured   (captures[i]),
            .done_mask  (done_mask[i]),
            .ch_time    (ch_time[LSB +: CNT_W]),
            .ch_max     (ch_max[LSB +: CNT_W])
        );
    end

endmodule

// File: tb/tb_timing_manager_nch.sv
// tb_timing_manager_nch
// Directed and randomized acquisition windows for timing_manager_nch, checked
// against an event-level model: expected times come from the done offsets
// chosen for each window, not from a cycle copy of the design.
module tb_timing_manager_nch;

    localparam int N_CH    = 10;
    localparam int CNT_W   = 16;
    localparam int RATIO_W = 16;
    localparam int BUS_W   = N_CH * CNT_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                event_qualifier;
    logic [RATIO_W-1:0]  user_ratio;
    logic [N_CH-1:0]     en_bits;
    logic [CNT_W-1:0]    timeout;
    logic [N_CH-1:0]     done;
    logic                clr_isr;
    logic                clr_max;
    logic [N_CH-1:0]     en;
    logic                trigger;
    logic                sched_isr;
    logic                timeout_flag;
    logic                overrun_flag;
    logic [N_CH-1:0]     late_mask;
    logic                busy;
    logic [CNT_W-1:0]    count_time;
    logic [BUS_W-1:0]    ch_time;
    logic [BUS_W-1:0]    ch_max;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_time[N_CH];
    int exp_max[N_CH];

    timing_manager_nch #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .RATIO_W (RATIO_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .event_qualifier (event_qualifier),
        .user_ratio      (user_ratio),
        .en_bits         (en_bits),
        .timeout         (timeout),
        .done            (done),
        .clr_isr         (clr_isr),
        .clr_max         (clr_max),
        .en              (en),
        .trigger         (trigger),
        .sched_isr       (sched_isr),
        .timeout_flag    (timeout_flag),
        .overrun_flag    (overrun_flag),
        .late_mask       (late_mask),
        .busy            (busy),
        .count_time      (count_time),
        .ch_time         (ch_time),
        .ch_max          (ch_max)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [BUS_W-1:0] observed,
                               input logic [BUS_W-1:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [BUS_W-1:0] packv(input int a[N_CH]);
        logic [BUS_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(a[i]);
        return v;
    endfunction

    // Fire one qualifier (user_ratio must be 0) and land at window time 0
    task automatic startWindow(input logic [N_CH-1:0] en_w);
        en_bits         = en_w;
        event_qualifier = 1'b1;
        tick();
        event_qualifier = 1'b0;
        checkOutput("trigger_pulse", trigger, 1'b1);
        tick();
        checkOutput("count_start", count_time, 0);
        checkOutput("busy_start", busy, en_w != '0);
        checkOutput("late_cleared", late_mask, 0);
    endtask

    // One window: channel i's done rises when window time reads d[i] (-1 = never)
    task automatic applyStimulus(input string tag, input logic [N_CH-1:0] en_w,
                                 input int t_out, input int d[N_CH], input int clr_at);
        bit all_have;
        bit tmo;
        int cmax;
        int end_t;
        logic [N_CH-1:0] capd;
        all_have = 1'b1;
        cmax     = 0;
        capd     = '0;
        timeout  = CNT_W'(t_out);
        for (int i = 0; i < N_CH; i++) begin
            if (en_w[i]) begin
                if (d[i] < 0) all_have = 1'b0;
                else if (d[i] > cmax) cmax = d[i];
            end
        end
        if (all_have && (t_out == 0 || cmax < t_out)) begin
            end_t = cmax;
            tmo   = 1'b0;
        end else begin
            end_t = t_out;
            tmo   = 1'b1;
        end
        for (int i = 0; i < N_CH; i++)
            capd[i] = en_w[i] && d[i] >= 0 && d[i] <= end_t;

        startWindow(en_w);
        en_bits = ~en_w;
        checkOutput("en_pass", en, en_bits);
        for (int t = 0; t <= end_t; t++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (d[i] >= 0 && t == d[i])     done[i] = 1'b1;
                if (d[i] >= 0 && t == d[i] + 3) done[i] = 1'b0;
                if (d[i] >= 0 && t == d[i] + 6) done[i] = 1'b1;
            end
            clr_max = (t == clr_at);
            checkOutput("count_time", count_time, t);
            checkOutput("busy_window", busy, 1'b1);
            checkOutput("isr_early", sched_isr, 1'b0);
            tick();
            clr_max = 1'b0;
            if (t == clr_at)
                for (int i = 0; i < N_CH; i++) exp_max[i] = 0;
            for (int i = 0; i < N_CH; i++) begin
                if (en_w[i] && d[i] == t) begin
                    exp_time[i] = t;
                    if (t > exp_max[i]) exp_max[i] = t;
                end
            end
        end
        $display("[TB] %s: en=%0h timeout=%0d end=%0d", tag, en_w, t_out, end_t);
        checkOutput({tag, "_busy_end"}, busy, 1'b0);
        checkOutput({tag, "_isr"}, sched_isr, 1'b1);
        checkOutput({tag, "_timeout_flag"}, timeout_flag, tmo);
        checkOutput({tag, "_late_mask"}, late_mask, tmo ? (en_w & ~capd) : '0);
        checkOutput({tag, "_overrun"}, overrun_flag, 1'b0);
        checkOutput({tag, "_ch_time"}, ch_time, packv(exp_time));
        checkOutput({tag, "_ch_max"}, ch_max, packv(exp_max));
        done    = '0;
        clr_isr = 1'b1;
        tick();
        clr_isr = 1'b0;
        checkOutput({tag, "_isr_clr"}, sched_isr, 1'b0);
        checkOutput({tag, "_tflag_clr"}, timeout_flag, 1'b0);
        tick();
    endtask

    initial begin
        int d[N_CH];
        rst_n           = 1'b0;
        event_qualifier = 1'b0;
        user_ratio      = '0;
        en_bits         = '0;
        timeout         = '0;
        done            = '0;
        clr_isr         = 1'b0;
        clr_max         = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            exp_time[i] = 0;
            exp_max[i]  = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_trigger", trigger, 0);
        checkOutput("rst_isr", sched_isr, 0);
        checkOutput("rst_flags", {timeout_flag, overrun_flag, busy}, 0);
        checkOutput("rst_late", late_mask, 0);
        checkOutput("rst_count", count_time, 0);
        checkOutput("rst_ch_time", ch_time, 0);
        checkOutput("rst_ch_max", ch_max, 0);
        rst_n = 1'b1;
        tick();

        // Divider: ratio 3 -> a trigger on every 4th qualifier; no enables, so no window
        user_ratio = 16'd3;
        for (int q = 1; q <= 8; q++) begin
            event_qualifier = 1'b1;
            tick();
            event_qualifier = 1'b0;
            checkOutput("ratio_trigger", trigger, (q % 4) == 0);
            tick();
            checkOutput("trigger_width", trigger, 0);
            checkOutput("en0_busy", busy, 0);
            checkOutput("en0_isr", sched_isr, 0);
            repeat (8) tick();
        end
        user_ratio = '0;

        // Two-channel completion window
        foreach (d[i]) d[i] = -1;
        d[0] = 50;
        d[9] = 120;
        applyStimulus("complete_201", 10'h201, 0, d, -1);

        // Timeout with channel 1 missing
        foreach (d[i]) d[i] = -1;
        d[0] = 40;
        applyStimulus("timeout_3", 10'h003, 100, d, -1);

        // Maxima: clear, then 30/80/50, then a capture coinciding with clr_max
        clr_max = 1'b1;
        tick();
        clr_max = 1'b0;
        for (int i = 0; i < N_CH; i++) exp_max[i] = 0;
        checkOutput("clr_max", ch_max, 0);
        foreach (d[i]) d[i] = -1;
        d[0] = 30;
        applyStimulus("max_30", 10'h001, 0, d, -1);
        d[0] = 80;
        applyStimulus("max_80", 10'h001, 0, d, -1);
        d[0] = 50;
        applyStimulus("max_50", 10'h001, 0, d, -1);
        checkOutput("ch_max0_80", ch_max[CNT_W-1:0], 80);
        d[0] = 20;
        applyStimulus("max_clr_20", 10'h001, 0, d, 20);
        checkOutput("ch_max0_20", ch_max[CNT_W-1:0], 20);

        // Overrun: retrigger mid-window with a done edge on the trigger cycle
        timeout = '0;
        startWindow(10'h001);
        repeat (30) tick();
        event_qualifier = 1'b1;
        tick();
        event_qualifier = 1'b0;
        checkOutput("overrun_trigger", trigger, 1);
        done[0] = 1'b1;
        tick();
        exp_time[0] = 0;
        checkOutput("overrun_flag", overrun_flag, 1);
        checkOutput("overrun_count", count_time, 0);
        checkOutput("overrun_busy", busy, 1);
        checkOutput("overrun_ch_time", ch_time, packv(exp_time));
        checkOutput("overrun_ch_max", ch_max, packv(exp_max));
        tick();
        checkOutput("overrun_complete", {busy, sched_isr}, 2'b01);
        done    = '0;
        clr_isr = 1'b1;
        tick();
        clr_isr = 1'b0;
        checkOutput("overrun_clr", {sched_isr, overrun_flag}, 0);
        tick();

        // Random windows
        for (int w = 0; w < 16; w++) begin
            logic [N_CH-1:0] en_r;
            int t_r;
            en_r = N_CH'($urandom_range(1, (1 << N_CH) - 1));
            t_r  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(60, 150));
            for (int i = 0; i < N_CH; i++) begin
                if (en_r[i] && t_r == 0) d[i] = int'($urandom_range(1, 150));
                else if ($urandom_range(0, 3) == 0) d[i] = -1;
                else d[i] = int'($urandom_range(1, 200));
                if (d[i] == t_r) d[i] = d[i] + 1;
            end
            applyStimulus("random", en_r, t_r, d, -1);
        end

        // Reset mid-window with done[0] held high through it
        timeout = '0;
        startWindow(10'h003);
        repeat (5) tick();
        done[0] = 1'b1;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N_CH; i++) begin
            exp_time[i] = 0;
            exp_max[i]  = 0;
        end
        checkOutput("midrst_flags", {trigger, sched_isr, timeout_flag, overrun_flag, busy}, 0);
        checkOutput("midrst_late", late_mask, 0);
        checkOutput("midrst_count", count_time, 0);
        checkOutput("midrst_ch_time", ch_time, 0);
        checkOutput("midrst_ch_max", ch_max, 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        startWindow(10'h001);
        for (int t = 0; t < 10; t++) begin
            checkOutput("held_no_capture", {busy, sched_isr}, 2'b10);
            tick();
        end
        checkOutput("held_ch_time", ch_time, 0);
        done[0] = 1'b0;
        tick();
        done[0] = 1'b1;
        tick();
        exp_time[0] = 11;
        exp_max[0]  = 11;
        checkOutput("rearm_done", {busy, sched_isr}, 2'b01);
        checkOutput("rearm_ch_time", ch_time, packv(exp_time));
        checkOutput("rearm_ch_max", ch_max, packv(exp_max));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timing_manager_nch.md
# timing_manager_nch

Parametrised sensor-acquisition timing manager. It divides a PWM-carrier event qualifier by a user ratio to produce a scheduler trigger. On each trigger it starts an acquisition window and timestamps each enabled sensor's done edge. It also tracks the worst-case time per channel, raises the scheduler interrupt when all enabled sensors finish, and flags timeouts and overruns. It sits between the PWM carrier, the sensor interface IPs and the AXI register file.

## Interface
Parameters:
- N_CH, 10, number of sensor channels
- CNT_W, 16, width of time counter, timeout and captured times
- RATIO_W, 16, width of user_ratio and the carrier-event counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- event_qualifier  in  1  one-cycle pulse per PWM carrier event
- user_ratio  in  RATIO_W  trigger every user_ratio+1 qualifier events
- en_bits  in  N_CH  per-channel enable
- timeout  in  CNT_W  acquisition limit in clk cycles; 0 disables
- done  in  N_CH  per-channel done level from sensor IPs
- clr_isr  in  1  pulse; clears sched_isr, timeout_flag, overrun_flag
- clr_max  in  1  pulse; clears all ch_max
- en  out  N_CH  = en_bits (combinational pass-through)
- trigger  out  1  one-cycle acquisition start pulse
- sched_isr  out  1  sticky interrupt to PS
- timeout_flag  out  1  sticky; last window ended by timeout
- overrun_flag  out  1  sticky; trigger arrived during ACQ
- late_mask  out  N_CH  enabled channels not done at timeout
- busy  out  1  high in ACQ
- count_time  out  CNT_W  cycles since last trigger, saturating
- ch_time  out  N_CH*CNT_W  last captured time, channel i at [i*CNT_W +: CNT_W]
- ch_max  out  N_CH*CNT_W  maximum captured time since clr_max/reset

## Operation
- Ratio counter: on event_qualifier, if count == user_ratio then count←0 and trigger←1; otherwise count←count+1. trigger is 0 in every other cycle. If user_ratio changes below count, the count is compared at the next qualifier and counts up, wrapping at 2^RATIO_W.
- FSM states IDLE and ACQ:
  - IDLE: on trigger, latch en_active←en_bits and clear done_mask. Go to ACQ if en_active≠0; otherwise stay in IDLE and raise no isr.
  - ACQ, all done: when (done_mask|captures) covers en_active, set sched_isr and go to IDLE.
  - ACQ, timeout: when timeout≠0 and count_time == timeout, set timeout_flag and sched_isr, set late_mask←en_active&~done_mask, and go to IDLE. If completion and timeout happen in the same cycle, completion wins and no timeout is flagged.
  - ACQ, trigger: set overrun_flag, re-latch en_active, clear done_mask, and stay in ACQ.
- count_time: cleared on trigger; otherwise increments and saturates at 2^CNT_W−1.
- Capture, per channel: a rising edge of done[i] (done & ~done_q) in ACQ with en_active[i] set and done_mask[i] clear does all of the following:
  - ch_time[i]←count_time
  - done_mask[i]←1
  - ch_max[i]←max(ch_max[i], count_time)
- Edges outside ACQ, on disabled channels, or repeated edges are ignored.
- Flags: a set in the same cycle as clr_isr wins. clr_max in the same cycle as a capture gives ch_max←count_time. late_mask is cleared on the next trigger.
- Reset: all outputs 0, FSM in IDLE, done_q←0.

## Timing
- trigger is registered and asserts 1 cycle after the qualifying event_qualifier.
- count_time reads 0 in the cycle after trigger.
- For a done[i] rising edge sampled at edge k, ch_time[i] updates at k+1 with the count_time value from edge k.
- sched_isr rises at the same edge as the final capture. No extra cycle.
- The timeout is detected at the edge where count_time == timeout, and the flags are visible the next cycle.
- Asserting rst_n low mid-ACQ aborts the window immediately. No isr is raised.

## Structure
- Package timing_manager_pkg holds:
  - the FSM state enum (IDLE, ACQ)
  - default parameter constants
  - the ch_time slice-index function
- Sub-module tm_channel_capture is generated N_CH times. It contains the done edge detect, the time latch, the max tracking and the done_mask bit. Inputs are acq, en_active bit, count_time and clr_max.

## Test plan
- user_ratio=3, qualifier every 10 cycles: trigger pulses once per 4 qualifiers, each 1 cycle wide.
- en_bits=0x201, done[0] rises 50 cycles after trigger and done[9] after 120: ch_time[0]=50, ch_time[9]=120, and sched_isr rises with the ch9 capture. clr_isr clears it.
- timeout=100, en_bits=0x3, only done[0] at 40: timeout_flag=1, sched_isr=1, late_mask=0x2, ch_time[1] unchanged.
- Trigger during ACQ: overrun_flag=1 and count_time restarts at 0. A done edge landing exactly on the trigger cycle is captured against the new window.
- ch_max: windows with ch0 times 30, 80, 50 give ch_max[0]=80. clr_max then a capture of 20 gives 20. en_bits=0 at trigger leaves busy=0 and sched_isr=0.
- rst_n pulsed mid-ACQ: all outputs 0. Next trigger starts a clean window, and a done level still high gives no capture until it falls and rises again.
